nmi_copy_engine: RTL
====================

# nmi_copy_engine

Initiator-side block for the native memory interface (NMI) used by the picorvino example SoC. It copies a block of 32-bit words from a source address range to a destination range by issuing NMI read and write transactions to an NMI responder, such as the on-chip memory. It is started by a one-cycle command and reports completion with a pulse. It sits beside the CPU as a second NMI initiator, ahead of the interconnect or arbiter.

## Interface
- ADDR_WIDTH, 32, NMI address width
- DATA_WIDTH, 32, NMI data width
- LEN_WIDTH, 16, width of the word-count field
- WSTRB_WIDTH, (DATA_WIDTH-1)/8+1, byte-strobe width
- clk  input  1  clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command pulse; sampled only in IDLE
- src_addr  input  ADDR_WIDTH  source byte address; low 2 bits ignored
- dst_addr  input  ADDR_WIDTH  destination byte address; low 2 bits ignored
- len  input  LEN_WIDTH  number of words to transfer
- busy  output  1  high from the cycle after start was accepted until DONE, inclusive
- done  output  1  one-cycle completion pulse
- m_mem_valid  output  1  transaction request
- m_mem_instr  output  1  tied 0
- m_mem_ready  input  1  responder accept; may be constantly 1
- m_mem_addr  output  ADDR_WIDTH  word-aligned byte address
- m_mem_wdata  output  DATA_WIDTH  write data
- m_mem_wstrb  output  WSTRB_WIDTH  all-ones for writes, 0 for reads
- m_mem_rdata  input  DATA_WIDTH  read data; valid in the cycle valid&&ready is high

## Operation
- Command capture: on start in IDLE, the block registers src, dst and len, and clears the word index idx.
- The block ignores start while busy.
- FSM states: IDLE, RD, WR, DONE.
- IDLE → RD when start is high and len≠0.
- IDLE → DONE when start is high and len=0. No NMI traffic is generated.
- RD: m_mem_valid=1, m_mem_addr=src+4·idx, m_mem_wstrb=0.
  - On valid&&ready, the block captures m_mem_rdata into a data buffer and moves to WR.
- WR: m_mem_valid=1, m_mem_addr=dst+4·idx, m_mem_wdata=buffer, m_mem_wstrb=all ones.
  - On valid&&ready, if idx=len−1 go to DONE; otherwise idx++ and go to RD.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Handshake rules:
  - addr, wdata and wstrb stay stable while valid is high and ready is low.
  - valid never drops before ready is seen.
  - Each transaction completes in the cycle valid&&ready is high.
- Address arithmetic: performed modulo 2^ADDR_WIDTH, so the address wraps past the top without error.
- Overlapping ranges are copied in ascending order; no overlap correction is performed.
- Reset mid-transfer: the FSM aborts to IDLE immediately. Any write whose handshake was not yet completed is dropped.

## Timing
- Reset values: m_mem_valid=0, m_mem_instr=0, m_mem_addr=0, m_mem_wdata=0, m_mem_wstrb=0, busy=0, done=0. State is IDLE and idx=0.
- All outputs are registered or decoded from state registers only. There is no combinational path from m_mem_ready or m_mem_rdata to outputs.
- start sampled at edge T → m_mem_valid first high in cycle T+1.
- With ready constantly 1, a copy of N words takes 2N cycles of traffic plus 1 DONE cycle, so done is high in cycle T+2N+1.
- With len=0, done is high in cycle T+1.
- Each cycle with ready low extends the current transaction by one cycle.

## Configuration
- NMI_COPY_FILL_EN defined:
  - Adds inputs fill_mode (1 bit) and fill_data (DATA_WIDTH).
  - If fill_mode=1 at start, the block skips RD entirely. Each word is a single WR of the captured fill_data, so N words take N traffic cycles.
- NMI_COPY_FILL_EN undefined: the fill ports are absent and the block always copies.

## Structure
- A shared package nmi_pkg holds the FSM state encoding, the NMI width defaults, and the WSTRB_WIDTH derivation.
- No sub-module: FSM, index counter and data buffer live in one module.

## Test plan
- Basic copy: preload mem[0x000..0x00C]=A0..A3, then start src=0x000, dst=0x400, len=4 with ready=1.
  - Expect mem[0x400..0x40C]=A0..A3.
  - Expect done in cycle T+9, busy high for cycles T+1..T+9, and exactly 8 handshakes.
- len=0: start with len=0.
  - Expect no m_mem_valid, done at T+1, busy for one cycle.
- Backpressure: ready toggling 0/1 randomly.
  - Expect addr, wdata and wstrb stable while valid&&!ready, correct data at the destination, and done delayed by the number of ready=0 cycles.
- Wrap and alignment: src=0xFFFFFFFC, dst=0x00000013, len=2.
  - Expect read addresses 0xFFFFFFFC, 0x00000000 and write addresses 0x10, 0x14.
- Reset mid-transfer: assert rst during the 3rd WR of an 8-word copy.
  - Expect valid=0 immediately and all outputs at reset values.
  - A new start after release runs correctly from idx 0.
- Fill, with NMI_COPY_FILL_EN defined: fill_mode=1, fill_data=0xDEADBEEF, dst=0x200, len=3.
  - Expect 3 writes, no reads, and done at T+4.

Source files
------------

// File: rtl/nmi_pkg.sv
// Shared NMI definitions: bus width defaults, strobe-width derivation and
// the copy-engine FSM state encoding.
package nmi_pkg;

  localparam int unsigned NMI_ADDR_WIDTH = 32;
  localparam int unsigned NMI_DATA_WIDTH = 32;
  localparam int unsigned NMI_LEN_WIDTH  = 16;

  // One strobe bit per (possibly partial) byte lane
  function automatic int unsigned nmi_wstrb_width(input int unsigned data_width);
    return (data_width - 1) / 8 + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } nmi_copy_state_e;

endpackage

// File: rtl/nmi_copy_engine.sv
// NMI initiator that copies len words from src_addr to dst_addr, one read then
// one write per word. Optional NMI_COPY_FILL_EN adds a write-only fill mode.
module nmi_copy_engine
  import nmi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = NMI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = NMI_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH   = NMI_LEN_WIDTH,
  parameter int unsigned WSTRB_WIDTH = nmi_wstrb_width(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef NMI_COPY_FILL_EN
  input  logic                   fill_mode,
  input  logic [DATA_WIDTH-1:0]  fill_data,
`endif
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  src_addr,
  input  logic [ADDR_WIDTH-1:0]  dst_addr,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic                   busy,
  output logic                   done,
  output logic                   m_mem_valid,
  output logic                   m_mem_instr,
  input  logic                   m_mem_ready,
  output logic [ADDR_WIDTH-1:0]  m_mem_addr,
  output logic [DATA_WIDTH-1:0]  m_mem_wdata,
  output logic [WSTRB_WIDTH-1:0] m_mem_wstrb,
  input  logic [DATA_WIDTH-1:0]  m_mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  nmi_copy_state_e       state_q, state_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  fill_q, fill_d;

  logic                   valid_d;
  logic                   busy_d;
  logic                   done_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [WSTRB_WIDTH-1:0] wstrb_d;

  logic                  hs_c;
  logic                  fill_req_c;
  logic [DATA_WIDTH-1:0] fill_word_c;

`ifdef NMI_COPY_FILL_EN
  assign fill_req_c  = fill_mode;
  assign fill_word_c = fill_data;
`else
  assign fill_req_c  = 1'b0;
  assign fill_word_c = '0;
`endif

  assign hs_c        = m_mem_valid && m_mem_ready;
  assign m_mem_instr = 1'b0;

  // Next-state, command capture and next registered-output values.
  // m_mem_wdata doubles as the read-data buffer between RD and WR.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    fill_d  = fill_q;
    wdata_d = m_mem_wdata;
    addr_d  = m_mem_addr;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = len;
          idx_d  = '0;
          fill_d = fill_req_c;
          if (len == '0) begin
            state_d = ST_DONE;
          end else if (fill_req_c) begin
            wdata_d = fill_word_c;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (hs_c) begin
          wdata_d = m_mem_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (hs_c) begin
          if (idx_q == len_q - LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + LEN_WIDTH'(1);
            state_d = fill_q ? ST_WR : ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_RD) || (state_d == ST_WR);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    wstrb_d = (state_d == ST_WR) ? {WSTRB_WIDTH{1'b1}} : '0;

    // Address wraps modulo 2^ADDR_WIDTH by plain truncating addition
    if (state_d == ST_RD) begin
      addr_d = (src_d & WORD_MASK) + (ADDR_WIDTH'(idx_d) << 2);
    end else if (state_d == ST_WR) begin
      addr_d = (dst_d & WORD_MASK) + (ADDR_WIDTH'(idx_d) << 2);
    end
  end

  // State, command registers and registered NMI outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      fill_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m_mem_valid <= 1'b0;
      m_mem_addr  <= '0;
      m_mem_wdata <= '0;
      m_mem_wstrb <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      fill_q      <= fill_d;
      busy        <= busy_d;
      done        <= done_d;
      m_mem_valid <= valid_d;
      m_mem_addr  <= addr_d;
      m_mem_wdata <= wdata_d;
      m_mem_wstrb <= wstrb_d;
    end
  end

endmodule
